// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch state encoding,
// instruction size and the jump opcodes that decode uses to drive jump/jal.
package pc_fetch_unit_pkg;

  // Fetch state encoding
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned ADDR_W      = 32;

  // Opcodes for decode-side jump recognition
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// pc_next_calc: combinational next-PC selection and fault detection.
// Ports:
//   pc, if_pc_plus4, if_valid          current PC and IF/ID state
//   jump_reg/jr_target, jump/jump_target, branch_taken/branch_offset  redirects
//   pc_plus4    sequential successor of pc
//   next_pc     selected next PC (redirect target or pc_plus4)
//   redirect    a redirect is being honoured (if_valid gated)
//   next_fault  next_pc is misaligned or beyond instruction memory
module pc_next_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 250
) (
  input  logic [31:0] pc,
  input  logic [31:0] if_pc_plus4,
  input  logic        if_valid,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        next_fault
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * INSTR_BYTES);

  logic [31:0] branch_disp;

  assign pc_plus4    = pc + 32'(INSTR_BYTES);
  // Word offset sign-extended and scaled to bytes
  assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  // Redirects only count when decode holds a live instruction
  assign redirect = if_valid & (jump_reg | jump | branch_taken);

  // Priority: jr > j/jal > branch > sequential
  always_comb begin
    next_pc = pc_plus4;
    if (if_valid) begin
      if (jump_reg) begin
        next_pc = jr_target;
      end else if (jump) begin
        next_pc = {if_pc_plus4[31:28], jump_target, 2'b00};
      end else if (branch_taken) begin
        next_pc = if_pc_plus4 + branch_disp;
      end
    end
  end

  assign next_fault = (next_pc[1:0] != 2'b00) || (next_pc >= MEM_BYTES);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter, drives the instruction-memory
// address and captures fetched instructions into the IF/ID register.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, halt           decode hazard hold / permanent stop request
//   branch_*, jump*, jr_* redirect requests from decode
//   instruction           combinational read data for pc_addr
//   pc_addr               current PC (straight from the flop)
//   if_instr, if_pc_plus4, if_valid  IF/ID register
//   fetch_fault           sticky bad-target flag
//   halted                stage is in HALTED state
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'd40,
  parameter int unsigned MEM_WORDS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc_addr,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_fault,
  output logic        halted
);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_instr_nxt, if_pc_plus4_nxt;
  logic        if_valid_nxt, fetch_fault_nxt;

  logic [31:0] pc_plus4, next_pc;
  logic        redirect, next_fault;

  pc_next_calc #(
    .MEM_WORDS(MEM_WORDS)
  ) u_next_calc (
    .pc            (pc),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .next_fault    (next_fault)
  );

  assign pc_addr = pc;

  // State and IF/ID registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= BOOT_ADDR;
      if_instr    <= '0;
      if_pc_plus4 <= '0;
      if_valid    <= 1'b0;
      fetch_fault <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_instr    <= if_instr_nxt;
      if_pc_plus4 <= if_pc_plus4_nxt;
      if_valid    <= if_valid_nxt;
      fetch_fault <= fetch_fault_nxt;
      halted      <= (state_nxt == ST_HALTED);
    end
  end

  // Next-state and register update selection
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_instr_nxt    = if_instr;
    if_pc_plus4_nxt = if_pc_plus4;
    if_valid_nxt    = if_valid;
    fetch_fault_nxt = fetch_fault;

    case (state)
      ST_BOOT: begin
        // Boot fetch is unconditional; decode inputs are meaningless here
        if_instr_nxt    = instruction;
        if_pc_plus4_nxt = pc_plus4;
        if_valid_nxt    = 1'b1;
        pc_nxt          = pc_plus4;
        state_nxt       = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt    = ST_HALTED;
          if_valid_nxt = 1'b0;
        end else if (!stall) begin
          if (next_fault) begin
            fetch_fault_nxt = 1'b1;
            state_nxt       = ST_HALTED;
            if_valid_nxt    = 1'b0;
          end else begin
            // Wrong-path fetch still loads IF/ID but is marked invalid
            if_instr_nxt    = instruction;
            if_pc_plus4_nxt = pc_plus4;
            if_valid_nxt    = ~redirect;
            pc_nxt          = next_pc;
          end
        end
      end
      ST_HALTED: begin
        if_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt    = ST_HALTED;
        if_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed walk through the fetch
// scenarios followed by randomized decode traffic, all checked against a
// behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  localparam logic [31:0] BOOT = 32'd40;
  localparam logic [31:0] MEM_BYTES = 32'd1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, halt, branch_taken, jump, jump_reg;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] instruction;
  logic [31:0] pc_addr, if_instr, if_pc_plus4;
  logic        if_valid, fetch_fault, halted;

  logic [31:0] imem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit          m_boot, m_halted, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_pc4;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .instruction   (instruction),
    .pc_addr       (pc_addr),
    .if_instr      (if_instr),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .fetch_fault   (fetch_fault),
    .halted        (halted)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a < 32'd1024) ? imem[a[9:2]] : 32'hDEAD_BEEF;
  endfunction

  assign instruction = mem_rd(pc_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    stall = 0; halt = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    branch_offset = '0; jump_target = '0; jr_target = '0;
  endtask

  // Advance one clock: update the model from current inputs, then compare.
  task automatic tick();
    longint nxt;
    bit redir;
    if (reset) begin
      m_boot = 1; m_halted = 0; m_pc = BOOT; m_instr = 0; m_pc4 = 0;
      m_valid = 0; m_fault = 0;
    end else if (m_boot) begin
      m_instr = mem_rd(m_pc); m_pc4 = m_pc + 4; m_pc = m_pc + 4;
      m_valid = 1; m_boot = 0;
    end else if (!m_halted) begin
      if (halt) begin
        m_halted = 1; m_valid = 0;
      end else if (!stall) begin
        redir = m_valid && (jump_reg || jump || branch_taken);
        if (m_valid && jump_reg)          nxt = jr_target;
        else if (m_valid && jump)         nxt = {m_pc4[31:28], jump_target, 2'b00};
        else if (m_valid && branch_taken) nxt = (longint'(m_pc4) + 4 * longint'($signed(branch_offset))) & 64'hFFFF_FFFF;
        else                              nxt = longint'(m_pc) + 4;
        if (nxt % 4 != 0 || nxt >= longint'(MEM_BYTES)) begin
          m_fault = 1; m_halted = 1; m_valid = 0;
        end else begin
          m_instr = mem_rd(m_pc); m_pc4 = m_pc + 4;
          m_valid = !redir; m_pc = 32'(nxt);
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("pc_addr", pc_addr, m_pc);
    check_eq("if_valid", 32'(if_valid), 32'(m_valid));
    check_eq("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check_eq("halted", 32'(halted), 32'(m_halted));
    if (m_valid) begin
      check_eq("if_instr", if_instr, m_instr);
      check_eq("if_pc_plus4", if_pc_plus4, m_pc4);
    end
  endtask

  task automatic do_reset();
    reset = 1; idle();
    tick();
    check_eq("rst_pc", pc_addr, BOOT);
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_fault", 32'(fetch_fault), 32'd0);
    check_eq("rst_instr", if_instr, 32'd0);
    reset = 0;
  endtask

  initial begin
    logic [31:0] held_instr, held_pc4;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    reset = 1; idle();

    // Sequential fetch out of reset
    do_reset();
    tick(); check_eq("seq_pc44", pc_addr, 32'd44); check_eq("seq_pc4_44", if_pc_plus4, 32'd44);
    check_eq("seq_valid", 32'(if_valid), 32'd1);
    tick(); check_eq("seq_pc48", pc_addr, 32'd48);
    tick(); check_eq("seq_pc52", pc_addr, 32'd52); check_eq("seq_pc4_52", if_pc_plus4, 32'd52);

    // Branch: if_pc_plus4 = 52 -> target 60
    branch_taken = 1; branch_offset = 16'h0002;
    tick(); check_eq("br_pc", pc_addr, 32'd60); check_eq("br_squash", 32'(if_valid), 32'd0);
    idle();
    tick(); check_eq("br_resume", 32'(if_valid), 32'd1); check_eq("br_pc4", if_pc_plus4, 32'd64);

    // Jump beats branch
    jump = 1; jump_target = 26'h8; branch_taken = 1; branch_offset = 16'h0010;
    tick(); check_eq("j_pc", pc_addr, 32'h20);
    idle();
    tick(); check_eq("j_resume", pc_addr, 32'h24);

    // Stall for 3 cycles, redirect during the first is ignored
    held_instr = if_instr; held_pc4 = if_pc_plus4;
    stall = 1; jump = 1; jump_target = 26'h30;
    tick(); jump = 0;
    tick(); tick();
    check_eq("stall_pc", pc_addr, 32'h24);
    check_eq("stall_instr", if_instr, held_instr);
    check_eq("stall_pc4", if_pc_plus4, held_pc4);
    idle();
    tick(); check_eq("stall_resume", pc_addr, 32'h28);

    // Misaligned jr target faults
    jump_reg = 1; jr_target = 32'h3EA;
    tick(); check_eq("jr_mis_fault", 32'(fetch_fault), 32'd1); check_eq("jr_mis_halt", 32'(halted), 32'd1);
    idle();
    tick(); tick(); check_eq("fault_sticky", 32'(fetch_fault), 32'd1);

    // Out-of-range jr target faults
    do_reset(); tick(); tick();
    jump_reg = 1; jr_target = 32'd1000;
    tick(); check_eq("jr_oor_fault", 32'(fetch_fault), 32'd1);
    idle(); tick();

    // Halt beats branch
    do_reset(); tick(); tick();
    halt = 1; branch_taken = 1; branch_offset = 16'h0004;
    tick(); check_eq("halt_pc", pc_addr, 32'd48); check_eq("halt_st", 32'(halted), 32'd1);
    check_eq("halt_nofault", 32'(fetch_fault), 32'd0);
    idle(); tick();
    do_reset(); check_eq("halt_reset_pc", pc_addr, 32'd40);

    // Randomized decode traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset = (m_halted && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      halt = ($urandom_range(0, 199) == 0);
      stall = ($urandom_range(0, 4) == 0);
      jump_reg = ($urandom_range(0, 14) == 0);
      jump = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jr_target = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1100) : 32'($urandom_range(0, 249) * 4);
      jump_target = 26'($urandom_range(0, 260));
      branch_offset = 16'($signed($urandom_range(0, 60)) - 30);
      if ($urandom_range(0, 49) == 0) branch_offset = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
